// File: rtl/sha256_msg_padder_if.sv
// Block stream between the SHA-256 message padder and the compression stage.
//   blk_data  : one 512-bit padded block; word 0 in [511:480], word 15 in [31:0]
//   blk_valid : blk_data holds a complete block
//   blk_ready : consumer accepts when blk_valid && blk_ready at a clock edge
//   blk_last  : qualifies blk_valid; this block is the final one of the message
// The padder uses the master modport and the compression stage uses the slave modport.
interface sha256_msg_padder_if;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_last;

    modport master (
        output blk_data,
        output blk_valid,
        output blk_last,
        input  blk_ready
    );

    modport slave (
        input  blk_data,
        input  blk_valid,
        input  blk_last,
        output blk_ready
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Fetches a byte-sized message from a word-addressed, read-only memory and applies
// FIPS 180-4 padding: a 0x80 marker byte, zero fill and a 64-bit big-endian bit length.
// Padded 512-bit blocks are offered one at a time on the blk interface.
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   start               1-cycle request, sampled only while idle
//   message_addr, size  word address of message word 0 and length in bytes
//   mem_clk, mem_we     memory clock (= clk) and write enable (always 0)
//   mem_addr            read word address (0 whenever no read is issued)
//   mem_read_data       read data, valid the cycle after mem_addr
//   blk                 block stream (master side)
//   busy, done          busy from the cycle after start; done pulses once at the end
module sha256_msg_padder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       size,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_read_data,
    sha256_msg_padder_if.master blk,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_PAD   = 2'd2;
    localparam logic [1:0] S_OFFER = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [31:0] size_q,      size_d;
    logic [31:0] msg_addr_q,  msg_addr_d;
    logic [31:0] blk_q,       blk_d;
    logic [4:0]  iss_q,       iss_d;
    logic        cap_vld_q,   cap_vld_d;
    logic [3:0]  cap_idx_q,   cap_idx_d;
    logic [31:0] words_q [16];
    logic [31:0] words_d [16];
    logic        blk_valid_q, blk_valid_d;
    logic        blk_last_q,  blk_last_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    // Block geometry. Offsets are kept in 38 bits so 64*blk never wraps.
    logic [37:0] blk_off;
    logic [37:0] size_ext;
    logic [37:0] rem;
    logic [4:0]  nw;
    logic [31:0] nb_m1;
    logic        is_last;
    logic        has_marker;
    logic        issue;
    logic [31:0] addr_full;
    logic [31:0] keep_mask;
    logic [31:0] marker;

    always_comb begin
        blk_off    = {blk_q, 6'b000000};
        size_ext   = {6'b000000, size_q};
        rem        = size_ext - blk_off;
        // Number of words in this block whose first byte lies inside the message.
        if (size_ext <= blk_off) begin
            nw = 5'd0;
        end else if (rem >= 38'd64) begin
            nw = 5'd16;
        end else begin
            nw = 5'(({1'b0, rem[5:0]} + 7'd3) >> 2);
        end
        nb_m1      = (size_q + 32'd8) >> 6;
        is_last    = (blk_q == nb_m1);
        has_marker = (size_ext >= blk_off) && (rem < 38'd64);
        issue      = (state_q == S_FETCH) && (iss_q < nw);
        addr_full  = msg_addr_q + {blk_q[27:0], 4'b0000} + {27'd0, iss_q};
        // Marker word keeps its top rem%4 message bytes; 0x80 sits right below them.
        keep_mask  = ~(32'hFFFF_FFFF >> {rem[1:0], 3'b000});
        marker     = 32'h0000_0080 << {2'd3 - rem[1:0], 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        msg_addr_d  = msg_addr_q;
        blk_d       = blk_q;
        iss_d       = iss_q;
        cap_vld_d   = 1'b0;
        cap_idx_d   = cap_idx_q;
        words_d     = words_q;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d     = size;
                    msg_addr_d = message_addr;
                    blk_d      = 32'd0;
                    iss_d      = 5'd0;
                    for (int w = 0; w < 16; w++) words_d[w] = 32'd0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // Capture of the previous address overlaps issue of the next one;
                // the cycle after the last issue only captures and then leaves.
                if (cap_vld_q) words_d[cap_idx_q] = mem_read_data;
                if (issue) begin
                    cap_vld_d = 1'b1;
                    cap_idx_d = iss_q[3:0];
                    iss_d     = iss_q + 5'd1;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (has_marker) begin
                    words_d[rem[5:2]] = (words_q[rem[5:2]] & keep_mask) | marker;
                end
                if (is_last) begin
                    words_d[14] = {29'd0, size_q[31:29]};
                    words_d[15] = {size_q[28:0], 3'b000};
                end
                blk_last_d  = is_last;
                blk_valid_d = 1'b1;
                state_d     = S_OFFER;
            end
            S_OFFER: begin
                if (blk_valid_q && blk.blk_ready) begin
                    blk_valid_d = 1'b0;
                    blk_last_d  = 1'b0;
                    if (blk_last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        blk_d   = blk_q + 32'd1;
                        iss_d   = 5'd0;
                        for (int w = 0; w < 16; w++) words_d[w] = 32'd0;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            size_q      <= 32'd0;
            msg_addr_q  <= 32'd0;
            blk_q       <= 32'd0;
            iss_q       <= 5'd0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= 4'd0;
            for (int w = 0; w < 16; w++) words_q[w] <= 32'd0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            msg_addr_q  <= msg_addr_d;
            blk_q       <= blk_d;
            iss_q       <= iss_d;
            cap_vld_q   <= cap_vld_d;
            cap_idx_q   <= cap_idx_d;
            for (int w = 0; w < 16; w++) words_q[w] <= words_d[w];
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign blk.blk_data[511-32*g -: 32] = words_q[g];
    end

    assign blk.blk_valid = blk_valid_q;
    assign blk.blk_last  = blk_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_clk       = clk;
    assign mem_we        = 1'b0;
    assign mem_addr      = issue ? ADDR_W'(addr_full) : '0;

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] message_addr;
    logic [31:0] size;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_read_data = 32'd0;
    logic        busy;
    logic        done;

    sha256_msg_padder_if blk_if ();

    sha256_msg_padder #(.ADDR_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .message_addr  (message_addr),
        .size          (size),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .blk           (blk_if),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    int n_chk  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    logic [511:0] exp_blk [$];
    logic [511:0] obs_blk [$];

    // Reads are visible as nonzero addresses while busy (messages never sit at 0).
    always @(negedge clk) begin
        if (busy && mem_addr != 16'd0) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Padded message as a byte stream: message, 0x80, zeros to 56 mod 64, 64-bit length.
    function automatic void build_model(input int unsigned sz, input int unsigned a);
        byte unsigned q[$];
        logic [31:0]  w;
        logic [63:0]  len;
        logic [511:0] bv;
        exp_blk.delete();
        for (int unsigned i = 0; i < sz; i++) begin
            w = mem[16'(a + i / 4)];
            q.push_back(w[31 - 8 * (i % 4) -: 8]);
        end
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        len = 64'(sz) * 64'd8;
        for (int k = 7; k >= 0; k--) q.push_back(len[8 * k +: 8]);
        for (int b = 0; b < q.size() / 64; b++) begin
            for (int j = 0; j < 64; j++) bv[511 - 8 * j -: 8] = q[64 * b + j];
            exp_blk.push_back(bv);
        end
    endfunction

    task automatic fill_mem(input int unsigned a, input int unsigned sz);
        for (int unsigned i = 0; i < (sz + 3) / 4 + 2; i++) mem[16'(a + i)] = $urandom;
    endtask

    task automatic run_msg(input int unsigned sz, input int unsigned a, input int stall, input bit poke);
        int t;
        int nw0;
        bit lst;
        logic [511:0] snap;
        logic snap_last;
        build_model(sz, a);
        obs_blk.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        nw0 = (sz >= 64) ? 16 : int'((sz + 3) / 4);
        @(negedge clk);
        size = sz; message_addr = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < exp_blk.size(); b++) begin
            t = 1;
            while (!blk_if.blk_valid && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!blk_if.blk_valid) begin
                chk("valid_timeout", 0, 1);
                return;
            end
            if (b == 0) chk("first_latency", t, nw0 + 3);
            snap = blk_if.blk_data;
            snap_last = blk_if.blk_last;
            for (int s = 0; s < stall; s++) begin
                if (poke && s == 0) begin
                    start = 1'b1; size = sz + 77; message_addr = a + 5;
                end
                @(negedge clk);
                start = 1'b0;
                chk("stall_data", blk_if.blk_data, snap);
                chk("stall_last", blk_if.blk_last, snap_last);
                chk("stall_valid", blk_if.blk_valid, 1);
            end
            obs_blk.push_back(blk_if.blk_data);
            for (int w = 0; w < 16; w++)
                chk($sformatf("b%0d_w%0d", b, w), blk_if.blk_data[511 - 32 * w -: 32],
                    exp_blk[b][511 - 32 * w -: 32]);
            lst = (b == exp_blk.size() - 1);
            chk("blk_last", blk_if.blk_last, lst);
            blk_if.blk_ready = 1'b1;
            @(negedge clk);
            blk_if.blk_ready = 1'b0;
            chk("valid_drop", blk_if.blk_valid, 0);
            chk("done_at_end", done, lst);
            chk("busy_after_hs", busy, !lst);
        end
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("read_count", rd_cnt, (sz + 3) / 4);
        chk("done_count", done_cnt, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, blk_if.blk_valid, 0);
        chk({tag, "_last"}, blk_if.blk_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_data"}, blk_if.blk_data, 0);
    endtask

    initial begin
        int unsigned a;
        int t;
        reset_n = 1'b0; start = 1'b0; size = 0; message_addr = 0;
        blk_if.blk_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // ready while nothing is offered does nothing
        blk_if.blk_ready = 1'b1;
        repeat (3) @(negedge clk);
        blk_if.blk_ready = 1'b0;
        chk("idle_ready_busy", busy, 0);
        chk("idle_ready_valid", blk_if.blk_valid, 0);

        // T1 empty message
        run_msg(0, 32'h0100, 0, 0);
        chk("t1_w0", obs_blk[0][511:480], 32'h8000_0000);
        chk("t1_rest", obs_blk[0][479:0], 0);

        // T2 "abc"
        fill_mem(32'h0200, 3);
        mem[16'h0200] = 32'h6162_6364;
        run_msg(3, 32'h0200, 0, 0);
        chk("t2_w0", obs_blk[0][511:480], 32'h6162_6380);
        chk("t2_w15", obs_blk[0][31:0], 32'h0000_0018);

        // T3 56 bytes
        for (int i = 0; i < 16; i++) mem[16'h0400 + i] = (i < 14) ? 32'h1111_1111 : 32'h5A5A_5A5A;
        run_msg(56, 32'h0400, 0, 0);
        chk("t3_b0_w14", obs_blk[0][63:32], 32'h8000_0000);
        chk("t3_b0_w15", obs_blk[0][31:0], 32'h0);
        chk("t3_b1_w0_13", obs_blk[1][511:64], 0);
        chk("t3_b1_w15", obs_blk[1][31:0], 32'h0000_01C0);

        // T4 exactly one block of message
        fill_mem(32'h0500, 64);
        run_msg(64, 32'h0500, 0, 0);
        chk("t4_b1_w0", obs_blk[1][511:480], 32'h8000_0000);
        chk("t4_b1_w15", obs_blk[1][31:0], 32'h0000_0200);

        // T5 130 bytes with a stalling consumer and a start pulse while busy
        fill_mem(32'h0600, 130);
        run_msg(130, 32'h0600, 10, 1);
        chk("t5_b2_w0", obs_blk[2][511:480], (mem[16'h0620] & 32'hFFFF_0000) | 32'h0000_8000);
        chk("t5_b2_w15", obs_blk[2][31:0], 32'h0000_0410);

        // T6 reset in the middle of block 1 of a 200-byte message
        fill_mem(32'h0800, 200);
        @(negedge clk);
        size = 200; message_addr = 32'h0800; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!blk_if.blk_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("t6_blk0_seen", blk_if.blk_valid, 1);
        blk_if.blk_ready = 1'b1;
        @(negedge clk);
        blk_if.blk_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        @(negedge clk);
        chk_reset_vals("t6_held");
        reset_n = 1'b1;
        fill_mem(32'h0200, 3);
        mem[16'h0200] = 32'h6162_6364;
        run_msg(3, 32'h0200, 0, 0);
        chk("t6_w0", obs_blk[0][511:480], 32'h6162_6380);
        chk("t6_w15", obs_blk[0][31:0], 32'h0000_0018);

        // randomized messages
        for (int r = 0; r < 14; r++) begin
            int unsigned sz;
            int st;
            sz = $urandom_range(0, 260);
            a  = $urandom_range(1, 60000);
            st = $urandom_range(0, 3);
            fill_mem(a, sz);
            run_msg(sz, a, st, st >= 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
